// File: rtl/icache_multiline_if.sv
// Fetch-side and memory-side signals of the multi-line instruction cache.
// The cache takes the slave modport; the fetcher/memory environment takes master.
interface icache_multiline_if;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        flush;
  logic [31:0] inst_out;
  logic        valid_out;
  logic        compressed_out;
  logic        mem_en;
  logic [31:0] miss_addr;
  logic        mem_grant;
  logic [7:0]  mem_byte;

  modport master (
    output req_valid, req_pc, flush, mem_grant, mem_byte,
    input  inst_out, valid_out, compressed_out, mem_en, miss_addr
  );

  modport slave (
    input  req_valid, req_pc, flush, mem_grant, mem_byte,
    output inst_out, valid_out, compressed_out, mem_en, miss_addr
  );
endinterface

// File: rtl/icache_multiline.sv
// Direct-mapped instruction cache returning 32 bits at a halfword-aligned pc,
// refilling whole lines byte-by-byte; fetches may straddle two lines.
module icache_multiline #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned NUM_LINES  = 16
) (
  input logic               clk_in,
  input logic               rst_in,
  icache_multiline_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;
  localparam int unsigned CNT_W = OFF_W + 1;

  localparam logic [CNT_W-1:0] LB_CNT       = CNT_W'(LINE_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(LINE_BYTES - 1);
  localparam logic [OFF_W-1:0] STRADDLE_OFF = OFF_W'(LINE_BYTES - 2);
  localparam logic [31:0]      LINE_MASK    = ~32'(LINE_BYTES - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  logic [0:0]           state, state_nx;
  logic [CNT_W-1:0]     iss, iss_nx, rcv, rcv_nx;
  logic                 pend, pend_nx;
  logic [31:0]          base, base_nx;
  logic [NUM_LINES-1:0] valid_q, valid_nx;
  logic                 mem_en_nx;
  logic [31:0]          miss_addr_nx;
  logic                 resp_nx;
  logic                 fill_we, fill_done;

  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [7:0]       data [NUM_LINES][LINE_BYTES];

  // Address split for the two halfwords of the fetch (pc and pc+2)
  logic [31:0]      pc_a, pc2, miss_base;
  logic [OFF_W-1:0] off0, off2;
  logic [IDX_W-1:0] idx0, idx1, ridx, miss_idx;
  logic [TAG_W-1:0] tag0, tag1;
  logic             straddle, hit0, hit1, hit;
  logic [31:0]      inst_nx;

  assign pc_a     = bus.req_pc & ~32'd1;
  assign pc2      = pc_a + 32'd2;
  assign off0     = pc_a[OFF_W-1:0];
  assign off2     = pc2[OFF_W-1:0];
  assign idx0     = pc_a[OFF_W +: IDX_W];
  assign idx1     = pc2[OFF_W +: IDX_W];
  assign tag0     = pc_a[31 -: TAG_W];
  assign tag1     = pc2[31 -: TAG_W];
  assign ridx     = base[OFF_W +: IDX_W];
  assign straddle = (off0 == STRADDLE_OFF);
  assign hit0     = valid_q[idx0] && (tags[idx0] == tag0);
  assign hit1     = valid_q[idx1] && (tags[idx1] == tag1);
  assign hit      = hit0 && (!straddle || hit1);

  // Line of pc is fetched before the line of pc+2
  assign miss_base = hit0 ? (pc2 & LINE_MASK) : (pc_a & LINE_MASK);
  assign miss_idx  = miss_base[OFF_W +: IDX_W];

  // pc,pc+1 always share a line; pc+2,pc+3 share the (possibly next) line
  assign inst_nx = {data[idx1][{off2[OFF_W-1:1], 1'b1}], data[idx1][off2],
                    data[idx0][{off0[OFF_W-1:1], 1'b1}], data[idx0][off0]};

  always_comb begin
    state_nx  = state;
    iss_nx    = iss;
    rcv_nx    = rcv;
    pend_nx   = 1'b0;
    base_nx   = base;
    valid_nx  = valid_q;
    resp_nx   = 1'b0;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    if (bus.flush) begin
      state_nx = ST_IDLE;
      valid_nx = '0;
    end else if (state == ST_IDLE) begin
      if (bus.req_valid && hit) begin
        resp_nx = 1'b1;
      end else if (bus.req_valid) begin
        state_nx           = ST_REFILL;
        base_nx            = miss_base;
        iss_nx             = '0;
        rcv_nx             = '0;
        valid_nx[miss_idx] = 1'b0;
      end
    end else begin
      // Byte granted last cycle arrives now
      if (pend) begin
        fill_we = 1'b1;
        rcv_nx  = rcv + CNT_W'(1);
        if (rcv == LAST_CNT) begin
          fill_done      = 1'b1;
          valid_nx[ridx] = 1'b1;
          state_nx       = ST_IDLE;
        end
      end
      if (bus.mem_en && bus.mem_grant) begin
        iss_nx  = iss + CNT_W'(1);
        pend_nx = 1'b1;
      end
    end
    mem_en_nx    = (state_nx == ST_REFILL) && (iss_nx < LB_CNT);
    miss_addr_nx = base_nx + 32'(iss_nx);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= ST_IDLE;
      iss                <= '0;
      rcv                <= '0;
      pend               <= 1'b0;
      base               <= '0;
      valid_q            <= '0;
      bus.mem_en         <= 1'b0;
      bus.miss_addr      <= '0;
      bus.valid_out      <= 1'b0;
      bus.inst_out       <= '0;
      bus.compressed_out <= 1'b0;
    end else begin
      state         <= state_nx;
      iss           <= iss_nx;
      rcv           <= rcv_nx;
      pend          <= pend_nx;
      base          <= base_nx;
      valid_q       <= valid_nx;
      bus.mem_en    <= mem_en_nx;
      bus.miss_addr <= miss_addr_nx;
      bus.valid_out <= resp_nx;
      if (resp_nx) begin
        bus.inst_out       <= inst_nx;
        bus.compressed_out <= (inst_nx[1:0] != 2'b11);
      end
    end
  end

  // Line storage needs no reset; the valid bits guard it
  always_ff @(posedge clk_in) begin
    if (fill_we) data[ridx][rcv[OFF_W-1:0]] <= bus.mem_byte;
    if (fill_done) tags[ridx] <= base[31 -: TAG_W];
  end
endmodule

// File: tb/tb_icache_multiline.sv
// Randomized bench for icache_multiline against a line-residency reference model
// driven by a synthetic byte-addressed backing memory.
module tb_icache_multiline;
  localparam int unsigned LB = 16;
  localparam int unsigned NL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  icache_multiline_if bus ();

  icache_multiline #(.LINE_BYTES(LB), .NUM_LINES(NL)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_vld [NL];
  logic [31:0] m_lb  [NL];
  bit          m_busy;
  logic [31:0] m_base;
  int          m_iss, m_rcv;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          exp_vout, exp_mem_en;
  logic [31:0] exp_inst, exp_addr;

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    if (a == 32'h300) return 8'h01;
    if (a == 32'h304) return 8'h13;
    return 8'(a * 32'd37 + (a >> 8) * 32'd11 + 32'd5);
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / LB) % NL;
  endfunction

  function automatic bit resident(input logic [31:0] a);
    logic [31:0] lb;
    lb = a & ~32'(LB - 1);
    return m_vld[idx_of(a)] && (m_lb[idx_of(a)] == lb);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
    m_busy = 0; m_pend = 0; m_iss = 0; m_rcv = 0;
    exp_vout = 0; exp_mem_en = 0; exp_addr = '0; exp_inst = '0;
  endtask

  // What the cache must do at the coming clock edge, given this cycle's inputs
  task automatic model_step(input bit rv, input logic [31:0] pc, input bit fl, input bit gr);
    logic [31:0] pa;
    bit h0, h1, hit, nv;
    logic [31:0] ni;
    pa  = pc & ~32'd1;
    h0  = resident(pa);
    h1  = ((pa % LB) != LB - 2) || resident(pa + 32'd2);
    hit = h0 && h1;
    nv  = rv && !m_busy && !fl && hit;
    ni  = {mem_at(pa + 32'd3), mem_at(pa + 32'd2), mem_at(pa + 32'd1), mem_at(pa)};
    if (fl) begin
      for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
      m_busy = 0;
      m_pend = 0;
    end else if (m_busy) begin
      if (m_pend) begin
        m_rcv++;
        if (m_rcv == LB) begin
          m_vld[idx_of(m_base)] = 1'b1;
          m_lb[idx_of(m_base)]  = m_base;
          m_busy = 0;
        end
      end
      if (exp_mem_en && gr) begin
        m_pend_addr = m_base + 32'(m_iss);
        m_iss++;
        m_pend = 1;
      end else begin
        m_pend = 0;
      end
    end else if (rv && !hit) begin
      m_busy = 1;
      m_base = h0 ? ((pa + 32'd2) & ~32'(LB - 1)) : (pa & ~32'(LB - 1));
      m_vld[idx_of(m_base)] = 1'b0;
      m_iss = 0; m_rcv = 0; m_pend = 0;
    end
    exp_vout   = nv;
    if (nv) exp_inst = ni;
    exp_mem_en = m_busy && (m_iss < LB);
    exp_addr   = m_base + 32'(m_iss);
  endtask

  // One clock: check last edge's outputs, then drive this cycle's inputs
  task automatic cyc(input bit rv, input logic [31:0] pc, input bit fl, input bit gr);
    @(negedge clk);
    check_eq("valid_out", 32'(bus.valid_out), 32'(exp_vout));
    if (exp_vout) begin
      check_eq("inst_out", bus.inst_out, exp_inst);
      check_eq("compressed_out", 32'(bus.compressed_out), 32'(exp_inst[1:0] != 2'b11));
    end
    check_eq("mem_en", 32'(bus.mem_en), 32'(exp_mem_en));
    if (exp_mem_en) check_eq("miss_addr", bus.miss_addr, exp_addr);
    bus.req_valid = rv;
    bus.req_pc    = pc;
    bus.flush     = fl;
    bus.mem_grant = gr;
    bus.mem_byte  = m_pend ? mem_at(m_pend_addr) : 8'($urandom);
    model_step(rv, pc, fl, gr);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check_eq("rst_inst_out", bus.inst_out, 32'd0);
    check_eq("rst_compressed", 32'(bus.compressed_out), 32'd0);
    check_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check_eq("rst_miss_addr", bus.miss_addr, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.mem_grant = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] b;
    case ($urandom_range(0, 6))
      0:       b = 32'h0000_0100;
      1:       b = 32'h0000_0200;
      2:       b = 32'h0000_0300;
      3:       b = 32'h0000_01F0;
      4:       b = 32'h0000_02F0;
      5:       b = 32'hFFFF_FFF0;
      default: b = 32'h0000_0000;
    endcase
    return b + 32'($urandom_range(0, 15));
  endfunction

  initial begin
    bus.req_valid = 1'b0; bus.req_pc = '0; bus.flush = 1'b0;
    bus.mem_grant = 1'b0; bus.mem_byte = '0;
    model_clear();
    do_reset();

    // Cold miss at 0x100 with continuous grants
    for (int k = 0; k < 22; k++) cyc(1, 32'h100, 0, 1);
    // Straddle from empty lines
    cyc(0, 32'h0, 1, 0);
    for (int k = 0; k < 42; k++) cyc(1, 32'h10E, 0, 1);
    // Conflicting tags on the same index
    for (int k = 0; k < 22; k++) cyc(1, 32'h200, 0, 1);
    for (int k = 0; k < 22; k++) cyc(1, 32'h100, 0, 1);
    // Grants stall every other cycle
    for (int k = 0; k < 40; k++) cyc(1, 32'h400, 0, (k % 2) == 0);
    // Flush mid-refill at receive count 7, then refetch
    for (int k = 0; k < 40 && !(m_busy && m_rcv == 7); k++) cyc(1, 32'h500, 0, 1);
    check_eq("flush_point_rcv", 32'(m_rcv), 32'd7);
    cyc(1, 32'h500, 1, 1);
    for (int k = 0; k < 24; k++) cyc(1, 32'h500, 0, 1);
    // Compressed vs full-width first byte
    for (int k = 0; k < 20; k++) cyc(1, 32'h300, 0, 1);
    cyc(1, 32'h304, 0, 1);
    cyc(0, 32'h0, 0, 1);
    // Reset in the middle of a refill
    for (int k = 0; k < 40 && !(m_busy && m_rcv == 5); k++) cyc(1, 32'h600, 0, 1);
    do_reset();
    for (int k = 0; k < 22; k++) cyc(1, 32'h600, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] pc;
      int hold;
      pc   = rand_pc();
      hold = $urandom_range(1, 24);
      for (int k = 0; k < hold; k++)
        cyc($urandom_range(0, 7) != 0, pc, $urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0);
    end
    cyc(0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_multiline.md
ICACHE_MULTILINE -- requirements
Module: icache_multiline

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 16, meaning bytes per cache line (power of 2, >= 4).
REQ-002 SHALL have parameter NUM_LINES, default 16, meaning number of direct-mapped lines (power of 2, >= 2).
REQ-003 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  fetcher requests instruction at req_pc this cycle.
REQ-006 SHALL have port req_pc  input  32  fetch address, halfword aligned (bit 0 ignored).
REQ-007 SHALL have port flush  input  1  invalidate all lines, abort refill.
REQ-008 SHALL have port inst_out  output  32  raw instruction bytes at req_pc, little-endian.
REQ-009 SHALL have port valid_out  output  1  inst_out/compressed_out valid this cycle.
REQ-010 SHALL have port compressed_out  output  1  inst_out[1:0] != 2'b11.
REQ-011 SHALL have port mem_en  output  1  byte read request to memory controller.
REQ-012 SHALL have port miss_addr  output  32  byte address of current request.
REQ-013 SHALL have port mem_grant  input  1  controller accepts request this cycle.
REQ-014 SHALL have port mem_byte  input  8  data for request granted in previous cycle.

Function
REQ-015 SHALL split address: offset = pc[log2(LINE_BYTES)-1:0], index = next log2(NUM_LINES) bits, tag = remaining upper bits; per line store tag, valid bit, LINE_BYTES data bytes.
REQ-016 SHALL define a fetch as hit when the line holding pc is valid with matching tag and, if offset == LINE_BYTES-2, the line holding pc+2 is also valid with matching tag.
REQ-017 SHALL, on req_valid && hit in cycle t, drive valid_out=1 in cycle t+1 with inst_out = bytes pc+3..pc and compressed_out from those bytes; otherwise valid_out=0 in t+1.
REQ-018 SHALL implement FSM IDLE, REFILL.
REQ-019 SHALL in IDLE, on req_valid && !hit && !flush, go to REFILL for the first missing line (line of pc before line of pc+2), latching line base address and index.
REQ-020 SHALL in REFILL assert mem_en while issue count < LINE_BYTES, miss_addr = base + issue count; issue count increments on mem_grant.
REQ-021 SHALL write mem_byte into the refill line at receive count in the cycle after each grant, then increment receive count.
REQ-022 SHALL, when receive count reaches LINE_BYTES, write tag, set valid, return to IDLE; the line is hittable from the following cycle.
REQ-023 SHALL clear the refill line's valid bit at REFILL entry so stale data never hits.
REQ-024 SHALL not respond with valid_out=1 while in REFILL, even if the request hits another line.
REQ-025 SHALL, on flush in any state, clear all valid bits and return to IDLE next cycle; mem_en deasserts that cycle; a byte returning the cycle after flush is discarded.
REQ-026 SHALL drop a pending refill fill on req_pc change only by completing it (refills are never aborted except by flush or reset).
REQ-027 SHALL keep counters log2(LINE_BYTES)+1 bits wide; miss_addr wraps modulo 2^32.
REQ-028 SHALL hold mem_en=0 in IDLE.

Reset
REQ-029 SHALL on rst_in asynchronously: all valid bits 0, state IDLE, counters 0, valid_out 0, compressed_out 0, inst_out 0, mem_en 0, miss_addr 0.
REQ-030 SHALL, if reset asserts mid-refill, discard the partial line; the line is not valid after reset release.

Verification
REQ-031 Cold miss, defaults: req pc 0x100, mem_grant always 1 -> mem_en for 16 cycles, miss_addr 0x100..0x10F, then valid_out=1 with bytes 0x103..0x100 one cycle after next request.
REQ-032 Straddle: lines empty, pc 0x10E -> two refills (0x100 then 0x110), then valid_out=1, inst_out={b[0x111],b[0x110],b[0x10F],b[0x10E]}.
REQ-033 Conflict: fill 0x100, then request 0x200 (same index) -> refill 0x200; re-request 0x100 misses again.
REQ-034 Stalled grants: mem_grant toggles 1,0 -> miss_addr holds while grant 0; data captured only after grants; 16 correct bytes.
REQ-035 Flush mid-refill at receive count 7 -> mem_en 0 next cycle, valid_out 0, re-request refetches whole line from base.
REQ-036 Compressed: byte pc = 0x01 -> compressed_out=1; byte 0x13 -> compressed_out=0.
